// File: rtl/l2_req_sched.sv
// rtl/l2_req_sched.sv - round-robin L2 refill request scheduler with outstanding cap and response routing
module l2_req_sched #(
    parameter int nstrms          = 64,
    parameter int nstrms_width    = $clog2(nstrms),
    parameter int l2_nstrms       = 16,
    parameter int l2_nstrms_width = $clog2(l2_nstrms),
    parameter int TILES           = nstrms / l2_nstrms,
    parameter int max_out         = 32,
    parameter int cnt_width       = $clog2(max_out + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [TILES-1:0]                   i_req_v,
    output logic [TILES-1:0]                   i_req_r,
    input  logic [TILES*nstrms_width-1:0]      i_req_sid,
    output logic                               o_req_v,
    input  logic                               o_req_r,
    output logic [nstrms_width-1:0]            o_req_sid,
    input  logic                               i_rsp_v,
    output logic                               i_rsp_r,
    input  logic [nstrms_width-1:0]            i_rsp_sid,
    output logic [TILES-1:0]                   o_rsp_v,
    input  logic [TILES-1:0]                   o_rsp_r,
    output logic [TILES*l2_nstrms_width-1:0]   o_rsp_sid,
    output logic [cnt_width-1:0]               o_outst,
    output logic                               o_err
);

    localparam int tw = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int dw = nstrms_width - l2_nstrms_width;
    localparam logic [cnt_width-1:0] max_cnt = cnt_width'(max_out);
    localparam logic [tw-1:0] last_tile = tw'(TILES - 1);

    logic [tw-1:0]  rr_ptr;
    logic [tw-1:0]  grant_idx;
    logic [tw-1:0]  cand_idx;
    logic           grant_v;
    logic           req_free;
    logic           can_issue;
    logic           grant;
    logic           rsp_free;
    logic           rsp_hs;
    logic [dw-1:0]  dst;
    int             cand;

    assign req_free  = ~o_req_v | o_req_r;
    assign can_issue = req_free & (o_outst < max_cnt);
    assign grant     = can_issue & grant_v;

    // First valid tile at or after rr_ptr, wrapping around.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < TILES; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= TILES) cand = cand - TILES;
            cand_idx = tw'(cand);
            if (!grant_v && i_req_v[cand_idx]) begin
                grant_v   = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // Ready is forced low while reset is held so no tile believes it was accepted.
    always_comb begin
        i_req_r = '0;
        if (reset && grant) i_req_r[grant_idx] = 1'b1;
    end

    assign rsp_free = ~|o_rsp_v | |(o_rsp_v & o_rsp_r);
    assign i_rsp_r  = reset & rsp_free;
    assign rsp_hs   = i_rsp_v & rsp_free;
    assign dst      = i_rsp_sid[nstrms_width-1:l2_nstrms_width];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_req_v   <= 1'b0;
            o_req_sid <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            o_req_v   <= 1'b1;
            o_req_sid <= i_req_sid[int'(grant_idx)*nstrms_width +: nstrms_width];
            rr_ptr    <= (grant_idx == last_tile) ? '0 : grant_idx + tw'(1);
        end else if (o_req_r) begin
            o_req_v   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_rsp_v   <= '0;
            o_rsp_sid <= '0;
        end else if (rsp_hs) begin
            o_rsp_v   <= TILES'(1) << dst;
            o_rsp_sid <= {TILES{i_rsp_sid[l2_nstrms_width-1:0]}};
        end else if (rsp_free) begin
            o_rsp_v   <= '0;
        end
    end

    // A response with nothing outstanding is flagged but never underflows the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_outst <= '0;
            o_err   <= 1'b0;
        end else begin
            if (rsp_hs && o_outst == '0) o_err <= 1'b1;
            if (grant && !rsp_hs) begin
                o_outst <= o_outst + cnt_width'(1);
            end else if (!grant && rsp_hs && o_outst != '0) begin
                o_outst <= o_outst - cnt_width'(1);
            end
        end
    end

endmodule

// File: tb/tb_l2_req_sched.sv
// tb/tb_l2_req_sched.sv - randomized bench for l2_req_sched against a transaction-level reference model
module tb_l2_req_sched;
    localparam int TILES = 4;
    localparam int NW    = 6;
    localparam int LW    = 4;
    localparam int MAXO  = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [TILES-1:0]     i_req_v;
    logic [TILES-1:0]     i_req_r;
    logic [TILES*NW-1:0]  i_req_sid;
    logic                 o_req_v;
    logic                 o_req_r;
    logic [NW-1:0]        o_req_sid;
    logic                 i_rsp_v;
    logic                 i_rsp_r;
    logic [NW-1:0]        i_rsp_sid;
    logic [TILES-1:0]     o_rsp_v;
    logic [TILES-1:0]     o_rsp_r;
    logic [TILES*LW-1:0]  o_rsp_sid;
    logic [5:0]           o_outst;
    logic                 o_err;

    l2_req_sched dut (
        .clk(clk), .reset(reset),
        .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid),
        .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_sid(o_req_sid),
        .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_sid(i_rsp_sid),
        .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_sid(o_rsp_sid),
        .o_outst(o_outst), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference state: tile index -1 means no response is being presented.
    int m_req_v, m_req_sid, m_rsp_t, m_rsp_sid, m_outst, m_err, m_rr;

    task automatic model_reset();
        m_req_v = 0; m_req_sid = 0; m_rsp_t = -1; m_rsp_sid = 0;
        m_outst = 0; m_err = 0; m_rr = 0;
    endtask

    // Called at a negedge with inputs already driven; checks, then advances one clock.
    task automatic cycle();
        int g, t, exp_req_r, exp_rsp_r, hs, n_req_v, n_req_sid, n_rsp_t, n_rsp_sid, n_outst, n_err, n_rr;
        bit can, rfree;
        #1;
        if (!reset) model_reset();
        can   = (m_req_v == 0 || o_req_r) && m_outst < MAXO;
        rfree = (m_rsp_t < 0) || o_rsp_r[m_rsp_t];
        g = -1;
        for (int k = 0; k < TILES; k++) begin
            t = (m_rr + k) % TILES;
            if (g < 0 && i_req_v[t]) g = t;
        end
        if (!can) g = -1;
        exp_req_r = (reset && g >= 0) ? (1 << g) : 0;
        exp_rsp_r = (reset && rfree) ? 1 : 0;
        check("i_req_r", i_req_r, exp_req_r);
        check("i_rsp_r", i_rsp_r, exp_rsp_r);
        check("o_req_v", o_req_v, m_req_v);
        check("o_req_sid", o_req_sid, m_req_sid);
        check("o_rsp_v", o_rsp_v, (m_rsp_t < 0) ? 0 : (1 << m_rsp_t));
        check("o_rsp_sid", o_rsp_sid, m_rsp_sid * 'h1111);
        check("o_outst", o_outst, m_outst);
        check("o_err", o_err, m_err);

        hs = (i_rsp_v && rfree) ? 1 : 0;
        n_req_v = m_req_v; n_req_sid = m_req_sid; n_rr = m_rr;
        if (g >= 0) begin
            n_req_v = 1; n_req_sid = (i_req_sid >> (g * NW)) & 63; n_rr = (g + 1) % TILES;
        end else if (o_req_r) begin
            n_req_v = 0;
        end
        n_rsp_t = m_rsp_t; n_rsp_sid = m_rsp_sid;
        if (hs) begin
            n_rsp_t = i_rsp_sid / 16; n_rsp_sid = i_rsp_sid % 16;
        end else if (rfree) begin
            n_rsp_t = -1;
        end
        n_outst = m_outst + ((g >= 0) ? 1 : 0) - hs;
        if (n_outst < 0) n_outst = 0;
        n_err = (m_err || (hs && m_outst == 0)) ? 1 : 0;

        @(posedge clk);
        if (reset) begin
            m_req_v = n_req_v; m_req_sid = n_req_sid; m_rr = n_rr;
            m_rsp_t = n_rsp_t; m_rsp_sid = n_rsp_sid; m_outst = n_outst; m_err = n_err;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_req_v = '0; i_req_sid = '0; o_req_r = 1'b1;
        i_rsp_v = 1'b0; i_rsp_sid = '0; o_rsp_r = '1;
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        idle_inputs();
        i_req_v   = 4'hF;
        i_req_sid = {6'd3, 6'd2, 6'd1, 6'd0};
        @(negedge clk);
        repeat (3) cycle();
        reset = 1'b1;

        // Saturate the outstanding budget.
        check("first_grant_tile0", {31'd0, (o_outst == 0)} & 1, 1);
        repeat (MAXO + 3) cycle();
        check("full_outst", o_outst, 32);
        check("full_no_grant", i_req_r, 0);

        // One response frees one credit and routes to tile 2, local sid 5.
        i_rsp_v = 1'b1; i_rsp_sid = 6'd37;
        cycle();
        i_rsp_v = 1'b0;
        check("rsp37_v", o_rsp_v, 4'b0100);
        check("rsp37_sid", o_rsp_sid[LW-1:0], 5);
        check("rsp37_outst", o_outst, 31);
        repeat (3) cycle();
        check("refill_outst", o_outst, 32);

        // Stalled tile 2 output with a new response pending.
        i_rsp_v = 1'b1; i_rsp_sid = 6'd38; o_rsp_r = 4'b1011;
        cycle();
        repeat (3) cycle();
        check("stall_rsp_v", o_rsp_v, 4'b0100);
        check("stall_rsp_r", i_rsp_r, 0);
        o_rsp_r = 4'hF;
        repeat (2) cycle();
        i_rsp_v = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            i_req_v   = 4'($urandom);
            i_req_sid = 24'($urandom);
            o_req_r   = ($urandom_range(0, 9) < 7);
            i_rsp_v   = ($urandom_range(0, 9) < ((n / 500) % 2 ? 7 : 4));
            i_rsp_sid = 6'($urandom);
            o_rsp_r   = 4'($urandom) | 4'($urandom);
            cycle();
        end

        // Response with nothing outstanding sets the sticky error.
        reset = 1'b0;
        idle_inputs();
        cycle();
        reset = 1'b1;
        check("err_clear", o_err, 0);
        i_rsp_v = 1'b1; i_rsp_sid = 6'd9;
        cycle();
        i_rsp_v = 1'b0;
        repeat (4) cycle();
        check("err_sticky", o_err, 1);
        check("err_outst", o_outst, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
